// File: rtl/sakebi_eth_pkg.sv
// Shared constants, FSM state encodings and a bit-reverse helper for the
// sakebi receive path.
package sakebi_eth_pkg;

  localparam int          MIN_LEN_DEF   = 64;
  localparam int          MAX_LEN_DEF   = 1518;
  localparam int          LEN_W         = 16;
  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  // Good-frame remainder, written in non-reflected bit order
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_RECV    = 2'd1,
    W_END     = 2'd2,
    W_DISCARD = 2'd3
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_LOAD = 2'd1,
    R_SEND = 2'd2
  } rd_state_t;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/sakebi_crc32_byte.sv
// Combinational one-byte step of the reflected Ethernet CRC-32.
// Only built when SAKEBI_RX_FCS_CHECK_EN is defined.
`ifdef SAKEBI_RX_FCS_CHECK_EN
module sakebi_crc32_byte
  import sakebi_eth_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  localparam logic [31:0] POLY_R = reflect32(CRC32_POLY);

  always_comb begin
    o_crc = i_crc ^ {24'h0, i_data};
    for (int i = 0; i < 8; i++) begin
      o_crc = o_crc[0] ? ((o_crc >> 1) ^ POLY_R) : (o_crc >> 1);
    end
  end

endmodule
`endif

// File: rtl/sakebi_rx_frame_ctrl.sv
// Receive frame sequencer: gap-delimited byte stream -> staged circular buffer
// -> committed AXI-Stream packets. SAKEBI_RX_FCS_CHECK_EN adds an FCS check.
module sakebi_rx_frame_ctrl
  import sakebi_eth_pkg::*;
#(
  parameter int BUF_AW     = 11,
  parameter int LQ_AW      = 2,
  parameter int GAP_CYCLES = 64,
  parameter int MIN_LEN    = MIN_LEN_DEF,
  parameter int MAX_LEN    = MAX_LEN_DEF
) (
  input  logic        i_axis_ACLK,
  input  logic        i_axis_ARESET,
  input  logic        i_rx_en,
  input  logic        i_rx_TVALID,
  input  logic [7:0]  i_rx_TDATA,
  output logic        o_axis_TVALID,
  output logic [7:0]  o_axis_TDATA,
  output logic        o_axis_TLAST,
  input  logic        i_axis_TREADY,
  output logic [15:0] o_frame_cnt,
  output logic [15:0] o_drop_cnt,
  output logic        o_busy,
  output logic [1:0]  o_dbg_wr_state,
  output logic [1:0]  o_dbg_rd_state
);

  localparam int                GAP_W     = $clog2(GAP_CYCLES + 1);
  localparam int                BUF_N     = 1 << BUF_AW;
  localparam int                LQ_N      = 1 << LQ_AW;
  localparam logic [BUF_AW:0]   BUF_DEPTH = {1'b1, {BUF_AW{1'b0}}};
  localparam logic [LQ_AW:0]    LQ_DEPTH  = {1'b1, {LQ_AW{1'b0}}};
  localparam logic [BUF_AW:0]   PTR_ONE   = (BUF_AW + 1)'(1);
  localparam logic [LQ_AW:0]    LQP_ONE   = (LQ_AW + 1)'(1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);
  localparam logic [LEN_W-1:0]  MIN_LEN_L = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0]  MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);

  wr_state_t r_wr_state, w_wr_next;
  rd_state_t r_rd_state, w_rd_next;

  logic [7:0]       r_mem    [BUF_N];
  logic [LEN_W-1:0] r_lq_mem [LQ_N];

  logic [BUF_AW:0]   r_wr_ptr, r_wr_tmp, r_rd_ptr, r_rd_addr;
  logic [LEN_W-1:0]  r_len, r_rlen, r_issue;
  logic [GAP_W-1:0]  r_gap;
  logic              r_mark;
  logic [15:0]       r_frame_cnt, r_drop_cnt;
  logic [LQ_AW:0]    r_lq_wr, r_lq_rd, r_lq_cnt;
  logic              r_q_vld, r_q_last;
  logic [7:0]        r_q_data;
  logic              r_out_valid, r_out_last;
  logic [7:0]        r_out_data;

  logic w_buf_full, w_lq_full, w_len_ovf, w_gap_done, w_start_ok;
  logic w_len_ok, w_fcs_ok, w_accept;
  logic w_store, w_mark_set, w_commit, w_reject, w_disc_end, w_rollback, w_drop_inc;
  logic w_busy;
  logic w_lq_nempty, w_out_free, w_pop, w_pipe, w_done, w_issue;
  logic [BUF_AW:0] w_rlen_ptr;

  // ---------------- write side ----------------
  assign w_buf_full = (r_wr_tmp - r_rd_ptr) == BUF_DEPTH;
  // Capacity counts frames committed but not yet fully sent, including the
  // one the read FSM is currently streaming.
  assign w_lq_full  = r_lq_cnt == LQ_DEPTH;
  assign w_len_ovf  = r_len >= MAX_LEN_L;
  assign w_gap_done = !i_rx_TVALID && (r_gap == GAP_LAST);
  assign w_start_ok = i_rx_en && !w_lq_full && !w_buf_full;
  assign w_len_ok   = (r_len >= MIN_LEN_L) && (r_len <= MAX_LEN_L);
  assign w_accept   = w_len_ok && w_fcs_ok;
  assign w_rollback = w_reject || w_disc_end;
  assign w_drop_inc = w_reject || (w_disc_end && r_mark);

  always_ff @(posedge i_axis_ACLK) begin
    if (i_axis_ARESET) r_wr_state <= W_IDLE;
    else               r_wr_state <= w_wr_next;
  end

  always_comb begin
    w_wr_next = r_wr_state;
    unique case (r_wr_state)
      W_IDLE:    if (i_rx_TVALID) w_wr_next = w_start_ok ? W_RECV : W_DISCARD;
      W_RECV: begin
        if (i_rx_TVALID) begin
          if (w_buf_full || w_len_ovf) w_wr_next = W_DISCARD;
        end else if (w_gap_done) begin
          w_wr_next = W_END;
        end
      end
      W_END:     w_wr_next = W_IDLE;
      W_DISCARD: if (w_gap_done) w_wr_next = W_IDLE;
      default:   w_wr_next = W_IDLE;
    endcase
  end

  always_comb begin
    w_store    = 1'b0;
    w_mark_set = 1'b0;
    w_commit   = 1'b0;
    w_reject   = 1'b0;
    w_disc_end = 1'b0;
    w_busy     = 1'b1;
    unique case (r_wr_state)
      W_IDLE: begin
        w_busy     = 1'b0;
        w_store    = i_rx_TVALID && w_start_ok;
        w_mark_set = i_rx_TVALID && i_rx_en && !w_start_ok;
      end
      W_RECV: begin
        w_store    = i_rx_TVALID && !(w_buf_full || w_len_ovf);
        w_mark_set = i_rx_TVALID && (w_buf_full || w_len_ovf);
      end
      W_END: begin
        w_commit = w_accept;
        w_reject = !w_accept;
      end
      W_DISCARD: w_disc_end = w_gap_done;
      default: ;
    endcase
  end

  always_ff @(posedge i_axis_ACLK) begin
    if (i_axis_ARESET) begin
      r_wr_ptr    <= '0;
      r_wr_tmp    <= '0;
      r_len       <= '0;
      r_gap       <= '0;
      r_mark      <= 1'b0;
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_rollback)   r_wr_tmp <= r_wr_ptr;
      else if (w_store) r_wr_tmp <= r_wr_tmp + PTR_ONE;
      if (w_commit) r_wr_ptr <= r_wr_tmp;
      if (r_wr_state == W_IDLE) r_len <= LEN_ONE;
      else if (w_store)         r_len <= r_len + LEN_ONE;
      if (i_rx_TVALID || r_wr_state == W_IDLE || r_wr_state == W_END) r_gap <= '0;
      else                                                            r_gap <= r_gap + GAP_ONE;
      if (r_wr_state == W_IDLE) r_mark <= w_mark_set;
      else if (w_mark_set)      r_mark <= 1'b1;
      if (w_commit) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_drop_inc && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

`ifdef SAKEBI_RX_FCS_CHECK_EN
  logic [31:0] r_crc, w_crc_in, w_crc_next;

  assign w_crc_in = (r_wr_state == W_IDLE) ? 32'hFFFF_FFFF : r_crc;

  sakebi_crc32_byte u_crc (
    .i_crc  (w_crc_in),
    .i_data (i_rx_TDATA),
    .o_crc  (w_crc_next)
  );

  always_ff @(posedge i_axis_ACLK) begin
    if (i_axis_ARESET) r_crc <= 32'hFFFF_FFFF;
    else if (w_store)  r_crc <= w_crc_next;
  end

  assign w_fcs_ok = reflect32(r_crc) == CRC32_RESIDUE;
`else
  assign w_fcs_ok = 1'b1;
`endif

  // ---------------- storage ----------------
  always_ff @(posedge i_axis_ACLK) begin
    if (w_store)  r_mem[r_wr_tmp[BUF_AW-1:0]] <= i_rx_TDATA;
    if (w_issue)  r_q_data <= r_mem[r_rd_addr[BUF_AW-1:0]];
    if (w_commit) r_lq_mem[r_lq_wr[LQ_AW-1:0]] <= r_len;
  end

  // ---------------- read side ----------------
  // Output handshake: a byte transfers on a clock edge where o_axis_TVALID and
  // i_axis_TREADY are both high; while TVALID is high without TREADY, TDATA
  // and TLAST hold. Read stage q prefetches so the output never bubbles.
  assign w_lq_nempty = r_lq_wr != r_lq_rd;
  assign w_out_free  = !r_out_valid || i_axis_TREADY;
  assign w_issue     = w_pipe && (r_issue != r_rlen) && (!r_q_vld || w_out_free);
  assign w_rlen_ptr  = r_rlen[BUF_AW:0];

  always_ff @(posedge i_axis_ACLK) begin
    if (i_axis_ARESET) r_rd_state <= R_IDLE;
    else               r_rd_state <= w_rd_next;
  end

  always_comb begin
    w_rd_next = r_rd_state;
    unique case (r_rd_state)
      R_IDLE:  if (w_lq_nempty) w_rd_next = R_LOAD;
      R_LOAD:  w_rd_next = R_SEND;
      R_SEND:  if (w_done) w_rd_next = R_IDLE;
      default: w_rd_next = R_IDLE;
    endcase
  end

  always_comb begin
    w_pop  = 1'b0;
    w_pipe = 1'b0;
    w_done = 1'b0;
    unique case (r_rd_state)
      R_IDLE: w_pop = w_lq_nempty;
      R_LOAD: w_pipe = 1'b1;
      R_SEND: begin
        w_pipe = 1'b1;
        w_done = r_out_valid && i_axis_TREADY && r_out_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_axis_ACLK) begin
    if (i_axis_ARESET) begin
      r_rd_ptr    <= '0;
      r_rd_addr   <= '0;
      r_lq_wr     <= '0;
      r_lq_rd     <= '0;
      r_lq_cnt    <= '0;
      r_rlen      <= '0;
      r_issue     <= '0;
      r_q_vld     <= 1'b0;
      r_q_last    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_commit) r_lq_wr <= r_lq_wr + LQP_ONE;
      unique case ({w_commit, w_done})
        2'b10:   r_lq_cnt <= r_lq_cnt + LQP_ONE;
        2'b01:   r_lq_cnt <= r_lq_cnt - LQP_ONE;
        default: ;
      endcase
      if (w_pop) begin
        r_rlen    <= r_lq_mem[r_lq_rd[LQ_AW-1:0]];
        r_lq_rd   <= r_lq_rd + LQP_ONE;
        r_rd_addr <= r_rd_ptr;
        r_issue   <= '0;
      end else if (w_issue) begin
        r_rd_addr <= r_rd_addr + PTR_ONE;
        r_issue   <= r_issue + LEN_ONE;
      end
      if (w_issue) begin
        r_q_vld  <= 1'b1;
        r_q_last <= r_issue == (r_rlen - LEN_ONE);
      end else if (w_pipe && w_out_free) begin
        r_q_vld  <= 1'b0;
      end
      if (w_pipe && w_out_free) begin
        r_out_valid <= r_q_vld;
        r_out_data  <= r_q_data;
        r_out_last  <= r_q_last;
      end
      if (w_done) r_rd_ptr <= r_rd_ptr + w_rlen_ptr;
    end
  end

  assign o_axis_TVALID  = r_out_valid;
  assign o_axis_TDATA   = r_out_data;
  assign o_axis_TLAST   = r_out_last;
  assign o_frame_cnt    = r_frame_cnt;
  assign o_drop_cnt     = r_drop_cnt;
  assign o_busy         = w_busy;
  assign o_dbg_wr_state = r_wr_state;
  assign o_dbg_rd_state = r_rd_state;

endmodule

// File: tb/tb_sakebi_rx_frame_ctrl.sv
// Directed bench for sakebi_rx_frame_ctrl; builds valid FCS trailers when
// SAKEBI_RX_FCS_CHECK_EN is defined.
module tb_sakebi_rx_frame_ctrl;

  localparam int GAP = 64;

  logic        clk = 1'b0;
  logic        rst, rx_en, rx_valid, tready;
  logic [7:0]  rx_data;
  logic        o_axis_TVALID, o_axis_TLAST, o_busy;
  logic [7:0]  o_axis_TDATA;
  logic [15:0] o_frame_cnt, o_drop_cnt;
  logic [1:0]  dbg_wr, dbg_rd;

  int          n_checks = 0;
  int          n_errors = 0;
  int          stall_viol = 0;
  logic        prev_stall = 1'b0;
  logic [8:0]  prev_word = '0;
  logic        timed_out;
  logic [8:0]  exp_q[$];
  logic [8:0]  got_q[$];
  logic [7:0]  tx_q[$];

  sakebi_rx_frame_ctrl #(.BUF_AW(11), .LQ_AW(2), .GAP_CYCLES(GAP)) dut (
    .i_axis_ACLK    (clk),
    .i_axis_ARESET  (rst),
    .i_rx_en        (rx_en),
    .i_rx_TVALID    (rx_valid),
    .i_rx_TDATA     (rx_data),
    .o_axis_TVALID  (o_axis_TVALID),
    .o_axis_TDATA   (o_axis_TDATA),
    .o_axis_TLAST   (o_axis_TLAST),
    .i_axis_TREADY  (tready),
    .o_frame_cnt    (o_frame_cnt),
    .o_drop_cnt     (o_drop_cnt),
    .o_busy         (o_busy),
    .o_dbg_wr_state (dbg_wr),
    .o_dbg_rd_state (dbg_rd)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Capture handshakes and watch output stability while stalled
  always @(negedge clk) begin
    if (prev_stall && (!o_axis_TVALID || {o_axis_TLAST, o_axis_TDATA} !== prev_word))
      stall_viol++;
    if (!rst && o_axis_TVALID && tready) got_q.push_back({o_axis_TLAST, o_axis_TDATA});
    prev_stall = !rst && o_axis_TVALID && !tready;
    prev_word  = {o_axis_TLAST, o_axis_TDATA};
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; rx_en = 1'b1; rx_valid = 1'b0; rx_data = '0; tready = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(2);
    got_q.delete();
    exp_q.delete();
    stall_viol = 0;
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic build_frame(input int len, input int base);
    tx_q.delete();
    for (int i = 0; i < len; i++) tx_q.push_back(8'(base + i));
`ifdef SAKEBI_RX_FCS_CHECK_EN
    begin
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < len - 4; i++) c = crc_step(c, tx_q[i]);
      c = ~c;
      for (int k = 0; k < 4; k++) tx_q[len-4+k] = c[8*k +: 8];
    end
`endif
  endtask

  task automatic expect_frame();
    for (int i = 0; i < tx_q.size(); i++) exp_q.push_back({i == tx_q.size() - 1, tx_q[i]});
  endtask

  task automatic send_frame(input int spacing);
    for (int i = 0; i < tx_q.size(); i++) begin
      rx_valid = 1'b1;
      rx_data  = tx_q[i];
      tick();
      if (spacing > 1) begin
        rx_valid = 1'b0;
        idle(spacing - 1);
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int t;
    t = 0;
    while (got_q.size() < n && t < 6000) begin
      tick();
      t++;
    end
    timed_out = got_q.size() < n;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({o_axis_TVALID, o_axis_TLAST, o_axis_TDATA} !== 10'h0) begin
      n_errors++; $display("FAIL reset_axis got %h want 000", {o_axis_TVALID, o_axis_TLAST, o_axis_TDATA});
    end
    n_checks++;
    if ({o_frame_cnt, o_drop_cnt} !== 32'h0) begin
      n_errors++; $display("FAIL reset_cnt got %h want 00000000", {o_frame_cnt, o_drop_cnt});
    end
    n_checks++;
    if (o_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b want 0", o_busy); end
  endtask

  task automatic test_min_frame();
    do_reset();
    build_frame(64, 0);
    expect_frame();
    send_frame(8);
    n_checks++;
    if (o_busy !== 1'b1) begin n_errors++; $display("FAIL t1_busy got %b want 1", o_busy); end
    idle(GAP + 8);
    wait_out(64);
    n_checks++;
    if (timed_out) begin n_errors++; $display("FAIL t1_timeout got %0d bytes want 64", got_q.size()); end
    n_checks++;
    if (got_q.size() != exp_q.size()) begin n_errors++; $display("FAIL t1_len got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL t1_byte[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_checks++;
    if (o_frame_cnt !== 16'd1 || o_drop_cnt !== 16'd0) begin
      n_errors++; $display("FAIL t1_cnt got %0d/%0d want 1/0", o_frame_cnt, o_drop_cnt);
    end
    n_checks++;
    if (o_busy !== 1'b0) begin n_errors++; $display("FAIL t1_idle got %b want 0", o_busy); end
  endtask

  task automatic test_runt();
    do_reset();
    build_frame(60, 8'h20);
    send_frame(1);
    idle(GAP + 8);
    n_checks++;
    if (o_drop_cnt !== 16'd1 || o_frame_cnt !== 16'd0 || got_q.size() != 0) begin
      n_errors++; $display("FAIL t2_runt got drop=%0d frame=%0d out=%0d want 1/0/0", o_drop_cnt, o_frame_cnt, got_q.size());
    end
    build_frame(100, 8'hA0);
    expect_frame();
    send_frame(1);
    idle(GAP + 8);
    wait_out(100);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin n_errors++; $display("FAIL t2_len got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL t2_byte[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_checks++;
    if (o_frame_cnt !== 16'd1 || o_drop_cnt !== 16'd1) begin
      n_errors++; $display("FAIL t2_cnt got %0d/%0d want 1/1", o_frame_cnt, o_drop_cnt);
    end
  endtask

  task automatic test_oversize();
    do_reset();
    build_frame(1519, 8'h11);
    send_frame(1);
    idle(GAP + 8);
    n_checks++;
    if (o_drop_cnt !== 16'd1 || o_frame_cnt !== 16'd0 || got_q.size() != 0) begin
      n_errors++; $display("FAIL t3_drop got drop=%0d frame=%0d out=%0d want 1/0/0", o_drop_cnt, o_frame_cnt, got_q.size());
    end
    n_checks++;
    if (dut.r_wr_ptr !== dut.r_rd_ptr || dut.r_wr_tmp !== dut.r_rd_ptr) begin
      n_errors++; $display("FAIL t3_ptr got wr=%h tmp=%h rd=%h want equal", dut.r_wr_ptr, dut.r_wr_tmp, dut.r_rd_ptr);
    end
    build_frame(1518, 8'h33);
    expect_frame();
    send_frame(1);
    idle(GAP + 8);
    wait_out(1518);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin n_errors++; $display("FAIL t3_len got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL t3_byte[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_checks++;
    if (o_frame_cnt !== 16'd1 || o_drop_cnt !== 16'd1) begin
      n_errors++; $display("FAIL t3_cnt got %0d/%0d want 1/1", o_frame_cnt, o_drop_cnt);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    tready = 1'b0;
    for (int f = 0; f < 5; f++) begin
      build_frame(64, 16 * f + 1);
      if (f < 4) expect_frame();
      send_frame(1);
      idle(GAP + 8);
    end
    n_checks++;
    if (o_frame_cnt !== 16'd4 || o_drop_cnt !== 16'd1) begin
      n_errors++; $display("FAIL t4_cnt got %0d/%0d want 4/1", o_frame_cnt, o_drop_cnt);
    end
    n_checks++;
    if (got_q.size() != 0 || o_axis_TVALID !== 1'b1 || o_axis_TDATA !== exp_q[0][7:0]) begin
      n_errors++; $display("FAIL t4_hold got out=%0d v=%b d=%h want 0/1/%h", got_q.size(), o_axis_TVALID, o_axis_TDATA, exp_q[0][7:0]);
    end
    tready = 1'b1;
    wait_out(256);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin n_errors++; $display("FAIL t4_len got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL t4_byte[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    build_frame(200, 8'h5C);
    expect_frame();
    fork
      send_frame(1);
      begin
        repeat (800) begin
          tready = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    tready = 1'b1;
    wait_out(200);
    n_checks++;
    if (stall_viol !== 0) begin n_errors++; $display("FAIL t5_stable got %0d changes want 0", stall_viol); end
    n_checks++;
    if (got_q.size() != exp_q.size()) begin n_errors++; $display("FAIL t5_len got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL t5_byte[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    build_frame(64, 8'h80);
    tx_q = tx_q[0:29];
    send_frame(1);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(2);
    build_frame(64, 8'h40);
    expect_frame();
    send_frame(1);
    idle(GAP + 8);
    wait_out(64);
    idle(4);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin n_errors++; $display("FAIL t6_len got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL t6_byte[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_checks++;
    if (o_frame_cnt !== 16'd1 || o_drop_cnt !== 16'd0) begin
      n_errors++; $display("FAIL t6_cnt got %0d/%0d want 1/0", o_frame_cnt, o_drop_cnt);
    end
`ifdef SAKEBI_RX_FCS_CHECK_EN
    build_frame(64, 8'h90);
    tx_q[63] = tx_q[63] ^ 8'h01;
    send_frame(1);
    idle(GAP + 20);
    n_checks++;
    if (o_drop_cnt !== 16'd1 || o_frame_cnt !== 16'd1 || got_q.size() != 64) begin
      n_errors++; $display("FAIL t6_fcs got drop=%0d frame=%0d out=%0d want 1/1/64", o_drop_cnt, o_frame_cnt, got_q.size());
    end
`endif
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; rx_en = 1'b1; rx_valid = 1'b0; rx_data = '0; tready = 1'b1;
    test_reset();
    test_min_frame();
    test_runt();
    test_oversize();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
